// File: rtl/iob_axi_m_axis_m_read_int.sv
// AXI4 read master that streams fetched 32-bit words out on an AXI-Stream port.
// A request crossing a 4 KiB boundary is issued as two INCR bursts.
module iob_axi_m_axis_m_read_int #(
    parameter int unsigned AXI_ADDR_W = 24,
    parameter int unsigned AXI_DATA_W = 32,
    parameter int unsigned AXI_LEN_W  = 8,
    parameter int unsigned AXI_ID_W   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // Transfer control
    input  logic [AXI_ADDR_W-1:0] r_addr_i,
    input  logic [AXI_LEN_W:0]    r_length_i,
    input  logic                  r_start_transfer_i,
    output logic                  r_busy_o,
    output logic                  r_error_o,
    // AXI-Stream master
    output logic [AXI_DATA_W-1:0] axis_out_data_o,
    output logic                  axis_out_valid_o,
    input  logic                  axis_out_ready_i,
    // AXI4 read address channel
    output logic [AXI_ADDR_W-1:0] axi_araddr_o,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    output logic [AXI_ID_W-1:0]   axi_arid_o,
    output logic [AXI_LEN_W-1:0]  axi_arlen_o,
    output logic [2:0]            axi_arsize_o,
    output logic [1:0]            axi_arburst_o,
    output logic [1:0]            axi_arlock_o,
    output logic [3:0]            axi_arcache_o,
    output logic [3:0]            axi_arqos_o,
    // AXI4 read data channel
    input  logic [AXI_DATA_W-1:0] axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rvalid_i,
    input  logic                  axi_rlast_i,
    input  logic [AXI_ID_W-1:0]   axi_rid_i,
    output logic                  axi_rready_o
);

    localparam int unsigned AW1 = AXI_ADDR_W + 1;
    localparam int unsigned LW1 = AXI_LEN_W + 1;

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e                state_q, state_d;
    logic [AXI_ADDR_W-1:0] araddr_q, araddr_d;
    logic [AXI_LEN_W-1:0]  arlen_q, arlen_d;
    logic [AXI_LEN_W-1:0]  cnt_q, cnt_d;
    logic [AXI_LEN_W:0]    remaining_q, remaining_d;
    logic                  arvalid_q, arvalid_d;
    logic                  out_valid_q, out_valid_d;
    logic [AXI_DATA_W-1:0] out_data_q, out_data_d;
    logic                  error_q, error_d;

    logic [AXI_ADDR_W:0]   last_addr;
    logic [12:0]           room;
    logic [AXI_LEN_W-1:0]  first_len;
    logic                  rready;
    logic                  beat;
    logic                  beat_is_last;
    logic                  unused_bits;

    // Last byte of the request; bit 12 tells whether it lands in the next 4 KiB page.
    assign last_addr = {1'b0, r_addr_i} + (AW1'(r_length_i) << 2) - AW1'(1);
    // Bytes left before the page boundary.
    assign room      = 13'h1000 - {1'b0, r_addr_i[11:0]};
    assign first_len = (r_addr_i[12] == last_addr[12]) ? AXI_LEN_W'(r_length_i - LW1'(1))
                                                       : AXI_LEN_W'((room >> 2) - 13'd1);

    // One-entry output register: accept a beat when it is empty or being drained.
    assign rready       = (state_q == StData) && (!out_valid_q || axis_out_ready_i);
    assign beat         = rready && axi_rvalid_i;
    assign beat_is_last = (cnt_q == arlen_q);

    assign unused_bits = ^{axi_rid_i, last_addr[AXI_ADDR_W:13], last_addr[11:0]};

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        arvalid_d   = arvalid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        error_d     = error_q;

        if (out_valid_q && axis_out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (beat) begin
            out_valid_d = 1'b1;
            out_data_d  = axi_rdata_i;
        end

        unique case (state_q)
            StIdle: begin
                if (r_start_transfer_i && (r_length_i != '0)) begin
                    araddr_d    = r_addr_i;
                    arlen_d     = first_len;
                    remaining_d = r_length_i - (LW1'(first_len) + LW1'(1));
                    cnt_d       = '0;
                    error_d     = 1'b0;
                    arvalid_d   = 1'b1;
                    state_d     = StAddr;
                end
            end
            StAddr: begin
                if (axi_arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (beat) begin
                    // Bad response or rlast disagreeing with our own count is sticky.
                    if ((axi_rresp_i != 2'b00) || (axi_rlast_i != beat_is_last)) begin
                        error_d = 1'b1;
                    end
                    if (beat_is_last) begin
                        if (remaining_q != '0) begin
                            araddr_d    = araddr_q +
                                          ((AXI_ADDR_W'(arlen_q) + AXI_ADDR_W'(1)) << 2);
                            arlen_d     = AXI_LEN_W'(remaining_q - LW1'(1));
                            remaining_d = '0;
                            cnt_d       = '0;
                            arvalid_d   = 1'b1;
                            state_d     = StAddr;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + AXI_LEN_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            araddr_q    <= '0;
            arlen_q     <= '0;
            cnt_q       <= '0;
            remaining_q <= '0;
            arvalid_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
            arvalid_q   <= arvalid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            error_q     <= error_d;
        end
    end

    // Busy covers the final buffered beat still waiting in the output register.
    assign r_busy_o         = (state_q != StIdle) || out_valid_q;
    assign r_error_o        = error_q;
    assign axis_out_data_o  = out_data_q;
    assign axis_out_valid_o = out_valid_q;
    assign axi_araddr_o     = araddr_q;
    assign axi_arvalid_o    = arvalid_q;
    assign axi_arlen_o      = arlen_q;
    assign axi_arid_o       = '0;
    assign axi_arsize_o     = 3'd2;
    assign axi_arburst_o    = 2'd1;
    assign axi_arlock_o     = 2'd0;
    assign axi_arcache_o    = 4'd2;
    assign axi_arqos_o      = 4'd0;
    assign axi_rready_o     = rready;

endmodule

// File: tb/tb_iob_axi_m_axis_m_read_int.sv
// Directed bench for iob_axi_m_axis_m_read_int with a hand-driven AXI read slave.
`timescale 1ns/1ps
module tb_iob_axi_m_axis_m_read_int;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int IW = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] r_addr = '0;
    logic [LW:0]   r_length = '0;
    logic          r_start = 1'b0;
    logic          r_busy, r_error;
    logic [DW-1:0] axis_data;
    logic          axis_valid, axis_ready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [IW-1:0] arid;
    logic [LW-1:0] arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst, arlock;
    logic [3:0]    arcache, arqos;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = '0;
    logic          rvalid = 1'b0;
    logic          rlast = 1'b0;
    logic [IW-1:0] rid = '0;
    logic          rready;

    int vecs = 0;
    int miscompares = 0;

    logic          tog_mode = 1'b0;
    logic          tog_bit = 1'b1;
    logic [3:0]    tog_pat = 4'b1001;  // ready sequence 1,0,0,1
    int            tog_idx = 0;

    logic [DW-1:0] out_q[$];
    int            out_cyc[$];
    int            cyc = 0;
    int            stall_viol = 0;
    int            stall_seen = 0;
    logic          held = 1'b0;
    logic [DW-1:0] held_data = '0;

    assign axis_ready = tog_mode ? tog_bit : 1'b1;

    iob_axi_m_axis_m_read_int #(
        .AXI_ADDR_W(AW),
        .AXI_DATA_W(DW),
        .AXI_LEN_W (LW),
        .AXI_ID_W  (IW)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .r_addr_i          (r_addr),
        .r_length_i        (r_length),
        .r_start_transfer_i(r_start),
        .r_busy_o          (r_busy),
        .r_error_o         (r_error),
        .axis_out_data_o   (axis_data),
        .axis_out_valid_o  (axis_valid),
        .axis_out_ready_i  (axis_ready),
        .axi_araddr_o      (araddr),
        .axi_arvalid_o     (arvalid),
        .axi_arready_i     (arready),
        .axi_arid_o        (arid),
        .axi_arlen_o       (arlen),
        .axi_arsize_o      (arsize),
        .axi_arburst_o     (arburst),
        .axi_arlock_o      (arlock),
        .axi_arcache_o     (arcache),
        .axi_arqos_o       (arqos),
        .axi_rdata_i       (rdata),
        .axi_rresp_i       (rresp),
        .axi_rvalid_i      (rvalid),
        .axi_rlast_i       (rlast),
        .axi_rid_i         (rid),
        .axi_rready_o      (rready)
    );

    always #5 clk = ~clk;

    // Stream ready pattern generator.
    always begin
        @(posedge clk);
        #1;
        tog_bit = tog_mode ? tog_pat[tog_idx % 4] : 1'b1;
        tog_idx = tog_mode ? tog_idx + 1 : 0;
    end

    // Stream monitor: records accepted beats and checks stalled data holds.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (axis_valid && axis_ready) begin
            out_q.push_back(axis_data);
            out_cyc.push_back(cyc);
        end
        if (held && !rst && (!axis_valid || (axis_data != held_data))) begin
            stall_viol <= stall_viol + 1;
        end
        if (axis_valid && !axis_ready && !rst) begin
            stall_seen <= stall_seen + 1;
        end
        held      <= axis_valid && !axis_ready && !rst;
        held_data <= axis_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [AW-1:0] a, input logic [LW:0] l);
        r_addr   = a;
        r_length = l;
        r_start  = 1'b1;
        @(posedge clk);
        #1;
        r_start  = 1'b0;
    endtask

    // Wait for AR, hold arready low for 'delay' cycles, checking the request stays put.
    task automatic serve_ar(input logic [AW-1:0] ea, input logic [LW-1:0] el, input int delay);
        int k;
        k = 0;
        while (!arvalid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("ar_valid_seen", 32'(arvalid), 32'd1);
        for (int d = 0; d <= delay; d++) begin
            chk("ar_valid_held", 32'(arvalid), 32'd1);
            chk("ar_addr", 32'(araddr), 32'(ea));
            chk("ar_len", 32'(arlen), 32'(el));
            if (d == delay) arready = 1'b1;
            @(posedge clk);
            #1;
        end
        arready = 1'b0;
        chk("ar_valid_drop", 32'(arvalid), 32'd0);
    endtask

    // Present n R beats back-to-back; each waits (bounded) for rready.
    task automatic send_r(input logic [31:0] base, input int n, input int err_idx,
                          input int last_idx);
        for (int i = 0; i < n; i++) begin
            bit taken;
            taken  = 1'b0;
            rdata  = base + 32'(i);
            rresp  = (i == err_idx) ? 2'd2 : 2'd0;
            rlast  = (i == last_idx);
            rvalid = 1'b1;
            for (int k = 0; k < 50 && !taken; k++) begin
                @(negedge clk);
                chk("rready_rule", 32'(rready), 32'(!axis_valid || axis_ready));
                if (rready) taken = 1'b1;
                @(posedge clk);
                #1;
            end
            chk("r_beat_taken", 32'(taken), 32'd1);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'd0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (r_busy && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("busy_drop", 32'(r_busy), 32'd0);
    endtask

    task automatic check_out(input int b, input logic [31:0] base, input int n);
        chk("out_count", 32'(out_q.size() - b), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (b + i < out_q.size()) chk("out_data", out_q[b + i], base + 32'(i));
        end
    endtask

    task automatic check_all_zero();
        chk("rst_busy", 32'(r_busy), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_axis_valid", 32'(axis_valid), 32'd0);
        chk("rst_error", 32'(r_error), 32'd0);
        chk("rst_araddr", 32'(araddr), 32'd0);
        chk("rst_arlen", 32'(arlen), 32'd0);
        chk("rst_axis_data", axis_data, 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
    endtask

    initial begin
        int b;

        // Reset state and constant AR fields.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero();
        chk("arsize", 32'(arsize), 32'd2);
        chk("arburst", 32'(arburst), 32'd1);
        chk("arcache", 32'(arcache), 32'd2);
        chk("arid", 32'(arid), 32'd0);
        chk("arlock", 32'(arlock), 32'd0);
        chk("arqos", 32'(arqos), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single burst, full throughput.
        b = out_q.size();
        start(24'h100, 9'd4);
        chk("t1_busy", 32'(r_busy), 32'd1);
        serve_ar(24'h100, 8'd3, 0);
        send_r(32'hA0, 4, -1, 3);
        chk("t1_last_valid", 32'(axis_valid), 32'd1);
        chk("t1_last_data", axis_data, 32'hA3);
        chk("t1_busy_hold", 32'(r_busy), 32'd1);
        @(posedge clk);
        #1;
        chk("t1_busy_fall", 32'(r_busy), 32'd0);
        chk("t1_valid_fall", 32'(axis_valid), 32'd0);
        chk("t1_error", 32'(r_error), 32'd0);
        check_out(b, 32'hA0, 4);
        for (int i = 0; i < 3; i++) begin
            if (b + i + 1 < out_cyc.size())
                chk("t1_consecutive", 32'(out_cyc[b + i + 1] - out_cyc[b + i]), 32'd1);
        end

        // 4 KiB crossing split into two bursts.
        b = out_q.size();
        start(24'hFF8, 9'd4);
        serve_ar(24'hFF8, 8'd1, 0);
        send_r(32'hB0, 2, -1, 1);
        serve_ar(24'h1000, 8'd1, 0);
        send_r(32'hB2, 2, -1, 1);
        wait_idle();
        check_out(b, 32'hB0, 4);
        chk("t2_error", 32'(r_error), 32'd0);

        // Maximum length with delayed arready.
        b = out_q.size();
        start(24'h0, 9'd256);
        serve_ar(24'h0, 8'd255, 5);
        send_r(32'h1000, 256, -1, 255);
        wait_idle();
        check_out(b, 32'h1000, 256);
        chk("t3_error", 32'(r_error), 32'd0);

        // Back-pressure on the stream.
        b = out_q.size();
        tog_mode = 1'b1;
        start(24'h200, 9'd8);
        serve_ar(24'h200, 8'd7, 0);
        send_r(32'hC0, 8, -1, 7);
        wait_idle();
        tog_mode = 1'b0;
        check_out(b, 32'hC0, 8);
        chk("t4_stable_while_stalled", 32'(stall_viol), 32'd0);
        chk("t4_stalls_seen", 32'(stall_seen > 0), 32'd1);

        // Error response on the second beat.
        b = out_q.size();
        start(24'h300, 9'd2);
        serve_ar(24'h300, 8'd1, 0);
        send_r(32'hD0, 2, 1, 1);
        wait_idle();
        check_out(b, 32'hD0, 2);
        chk("t5_error_set", 32'(r_error), 32'd1);

        // Zero-length start is ignored and leaves the error flag alone.
        start(24'h500, 9'd0);
        chk("t5_len0_busy", 32'(r_busy), 32'd0);
        chk("t5_len0_arvalid", 32'(arvalid), 32'd0);
        chk("t5_error_kept", 32'(r_error), 32'd1);

        // Reset mid-burst, then a fresh transfer.
        start(24'h400, 9'd8);
        chk("t6_error_cleared", 32'(r_error), 32'd0);
        serve_ar(24'h400, 8'd7, 0);
        send_r(32'hE0, 2, -1, 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero();
        b = out_q.size();
        start(24'h40, 9'd1);
        serve_ar(24'h40, 8'd0, 0);
        send_r(32'hF0, 1, -1, 0);
        wait_idle();
        check_out(b, 32'hF0, 1);
        chk("t6_error", 32'(r_error), 32'd0);

        // rlast asserted early is flagged.
        b = out_q.size();
        start(24'h600, 9'd2);
        serve_ar(24'h600, 8'd1, 0);
        send_r(32'h10, 2, -1, 0);
        wait_idle();
        check_out(b, 32'h10, 2);
        chk("t7_rlast_error", 32'(r_error), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
